// File: rtl/ifu_prefetch_queue_pkg.sv
// Shared constants for the instruction-fetch prefetch queue: IF->ID bus layout
// and the ebreak encoding recognised on fill.
package ifu_prefetch_queue_pkg;

    localparam int IFU_ADDR_W     = 32;
    localparam int IF_TO_ID_WIDTH = 33 + IFU_ADDR_W;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    localparam int BUS_PC_LSB     = 0;
    localparam int BUS_INST_LSB   = IFU_ADDR_W;
    localparam int BUS_EBREAK_BIT = IF_TO_ID_WIDTH - 1;

    function automatic logic is_ebreak(input logic [31:0] inst);
        return inst == EBREAK_INST;
    endfunction

endpackage

// File: rtl/ifu_fetch_queue.sv
// In-order fetch buffer: entries are allocated at request time, filled in
// request order by responses and retired from the head.
module ifu_fetch_queue
    import ifu_prefetch_queue_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         alloc,
    input  logic [ADDR_W-1:0]            alloc_pc,
    input  logic                         fill,
    input  logic [31:0]                  fill_inst,
    input  logic                         deq,
    output logic                         head_filled,
    output logic [ADDR_W-1:0]            head_pc,
    output logic [31:0]                  head_inst,
    output logic                         head_ebreak,
    output logic                         fill_hi_word,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(DEPTH+1)-1:0]   pend_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc_q     [DEPTH];
    logic [31:0]       inst_q   [DEPTH];
    logic              ebreak_q [DEPTH];
    logic [DEPTH-1:0]  filled_q;
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [PTR_W-1:0]  fptr_q;

    // Control state; a flush frees everything and realigns all pointers on tail.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            fptr_q   <= '0;
            count    <= '0;
            pend_cnt <= '0;
            filled_q <= '0;
        end else if (flush) begin
            head_q   <= tail_q;
            fptr_q   <= tail_q;
            count    <= '0;
            pend_cnt <= '0;
            filled_q <= '0;
        end else begin
            if (alloc) tail_q <= tail_q + PTR_W'(1);
            if (fill) begin
                filled_q[fptr_q] <= 1'b1;
                fptr_q           <= fptr_q + PTR_W'(1);
            end
            if (deq) begin
                filled_q[head_q] <= 1'b0;
                head_q           <= head_q + PTR_W'(1);
            end
            count    <= count + CNT_W'(alloc) - CNT_W'(deq);
            pend_cnt <= pend_cnt + CNT_W'(alloc) - CNT_W'(fill);
        end
    end

    // Payload storage is never reset; validity lives only in filled_q.
    always_ff @(posedge clk) begin
        if (alloc) pc_q[tail_q] <= alloc_pc;
        if (fill) begin
            inst_q[fptr_q]   <= fill_inst;
            ebreak_q[fptr_q] <= is_ebreak(fill_inst);
        end
    end

    assign head_filled  = filled_q[head_q];
    assign head_pc      = pc_q[head_q];
    assign head_inst    = inst_q[head_q];
    assign head_ebreak  = ebreak_q[head_q];
    assign fill_hi_word = pc_q[fptr_q][2];

endmodule

// File: rtl/ifu_prefetch_queue.sv
// Decoupled IF stage: issues PC requests ahead of ID, buffers in-order
// responses and discards stale ones after a redirect by counting them.
module ifu_prefetch_queue
    import ifu_prefetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = IFU_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000,
    parameter int                DEPTH    = 4,
    parameter int                MEM_DW   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_W-1:0]     redirect_pc,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [ADDR_W-1:0]     req_addr,
    input  logic                  resp_valid,
    input  logic [MEM_DW-1:0]     resp_data,
    input  logic                  id_allowin,
    output logic                  if_to_id_valid,
    output logic [32+ADDR_W:0]    if_to_id_bus,
    output logic [ADDR_W-1:0]     fetch_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  pend_cnt;
    logic [CNT_W-1:0]  drop_cnt;
    logic              credit_ok;
    logic              alloc;
    logic              fill;
    logic              deq;
    logic              head_filled;
    logic [ADDR_W-1:0] head_pc;
    logic [31:0]       head_inst;
    logic              head_ebreak;
    logic              fill_hi_word;
    logic [31:0]       fill_inst;

    // Discarded-but-outstanding responses still occupy a memory slot.
    assign credit_ok = ({1'b0, count} + {1'b0, drop_cnt}) < (CNT_W+1)'(DEPTH);
    assign req_valid = rst && !redirect_valid && credit_ok;
    assign req_addr  = fetch_pc;
    assign alloc     = req_valid && req_ready;

    assign fill      = resp_valid && (drop_cnt == '0) && !redirect_valid;
    assign fill_inst = fill_hi_word ? resp_data[63:32] : resp_data[31:0];

    assign if_to_id_valid = head_filled && !redirect_valid;
    assign deq            = if_to_id_valid && id_allowin;
    assign if_to_id_bus   = head_filled ? {head_ebreak, head_inst, head_pc} : '0;

    ifu_fetch_queue #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clk          (clk),
        .rst          (rst),
        .flush        (redirect_valid),
        .alloc        (alloc),
        .alloc_pc     (fetch_pc),
        .fill         (fill),
        .fill_inst    (fill_inst),
        .deq          (deq),
        .head_filled  (head_filled),
        .head_pc      (head_pc),
        .head_inst    (head_inst),
        .head_ebreak  (head_ebreak),
        .fill_hi_word (fill_hi_word),
        .count        (count),
        .pend_cnt     (pend_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
        end else if (alloc) begin
            fetch_pc <= fetch_pc + ADDR_W'(4);
        end
    end

    // A response arriving with the redirect is the oldest old-stream beat,
    // so it is netted out of the newly orphaned requests.
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else begin
            if (resp_valid) assert (drop_cnt != '0 || pend_cnt != '0);
            if (redirect_valid) begin
                drop_cnt <= drop_cnt + pend_cnt - CNT_W'(resp_valid);
            end else if (resp_valid && drop_cnt != '0) begin
                drop_cnt <= drop_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ifu_prefetch_queue.sv
// Self-checking bench: queue-based reference model plus an in-order memory
// with per-request latency, directed scenarios then random traffic.
module tb_ifu_prefetch_queue;
    import ifu_prefetch_queue_pkg::*;

    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int BW    = 33 + AW;
    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          rst, redirect_valid, req_valid, req_ready, resp_valid;
    logic          id_allowin, if_to_id_valid;
    logic [AW-1:0] redirect_pc, req_addr, fetch_pc;
    logic [63:0]   resp_data;
    logic [BW-1:0] if_to_id_bus;

    always #5 clk = ~clk;

    ifu_prefetch_queue #(.ADDR_W(AW), .RESET_PC(RST_PC), .DEPTH(DEPTH), .MEM_DW(64)) dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_data(resp_data), .id_allowin(id_allowin),
        .if_to_id_valid(if_to_id_valid), .if_to_id_bus(if_to_id_bus), .fetch_pc(fetch_pc)
    );

    typedef struct { logic [31:0] pc; logic filled; logic [31:0] inst; } ent_t;
    typedef struct { logic [31:0] addr; int due; logic live; } mreq_t;

    ent_t          fifo[$];
    mreq_t         mem[$];
    logic [31:0]   m_fetch;
    int            cyc, lat, n_vec, n_err;
    bit            chk_en;
    logic          exp_req_valid, exp_valid;
    logic [BW-1:0] exp_bus;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0013;
        if (a == 32'h8000_0004) return EBREAK_INST;
        if (a[6:2] == 5'd9) return EBREAK_INST;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    function automatic int dead_cnt();
        int n = 0;
        foreach (mem[i]) if (!mem[i].live) n++;
        return n;
    endfunction

    task automatic compute_exp();
        bit head_ok;
        head_ok       = fifo.size() > 0 && fifo[0].filled;
        exp_req_valid = rst && !redirect_valid && (fifo.size() + dead_cnt() < DEPTH);
        exp_valid     = head_ok && !redirect_valid;
        exp_bus       = head_ok ? {fifo[0].inst == EBREAK_INST, fifo[0].inst, fifo[0].pc} : '0;
    endtask

    // Advance the model by the cycle that just ended at this posedge.
    task automatic model_update();
        mreq_t r;
        bit    done;
        if (!rst) begin
            fifo.delete();
            mem.delete();
            m_fetch = RST_PC;
        end else if (redirect_valid) begin
            if (resp_valid) r = mem.pop_front();
            foreach (mem[i]) mem[i].live = 1'b0;
            fifo.delete();
            m_fetch = redirect_pc;
        end else begin
            if (resp_valid) begin
                r = mem.pop_front();
                done = 0;
                if (r.live) begin
                    for (int i = 0; i < fifo.size(); i++) begin
                        if (!done && !fifo[i].filled) begin
                            fifo[i].filled = 1'b1;
                            fifo[i].inst   = word_at(r.addr);
                            done = 1;
                        end
                    end
                end
            end
            if (exp_valid && id_allowin) void'(fifo.pop_front());
            if (exp_req_valid && req_ready) begin
                fifo.push_back('{pc: m_fetch, filled: 1'b0, inst: 32'h0});
                mem.push_back('{addr: m_fetch, due: cyc + lat, live: 1'b1});
                m_fetch = m_fetch + 32'd4;
            end
        end
    endtask

    task automatic step(input bit r, input bit rd, input logic [31:0] rpc, input bit rdy, input bit alw);
        @(posedge clk);
        model_update();
        cyc++;
        chk_en = 1;
        #1;
        rst = r; redirect_valid = rd; redirect_pc = rpc; req_ready = rdy; id_allowin = alw;
        if (rst && mem.size() > 0 && mem[0].due <= cyc) begin
            resp_valid = 1'b1;
            resp_data  = {word_at(mem[0].addr | 32'h4), word_at(mem[0].addr & ~32'h7)};
        end else begin
            resp_valid = 1'b0;
            resp_data  = {$urandom, $urandom};
        end
        compute_exp();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("req_valid", req_valid, exp_req_valid);
            check("req_addr", req_addr, m_fetch);
            check("fetch_pc", fetch_pc, m_fetch);
            check("if_to_id_valid", if_to_id_valid, exp_valid);
            check("if_to_id_bus", if_to_id_bus, exp_bus);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, k;
        bit seen;
        rst = 0; redirect_valid = 0; redirect_pc = 0; req_ready = 0; id_allowin = 0;
        resp_valid = 0; resp_data = 0; lat = 1; n_vec = 0; n_err = 0; cyc = 0;
        chk_en = 0; m_fetch = RST_PC; exp_req_valid = 0; exp_valid = 0; exp_bus = '0;

        // Streaming from reset with single-cycle memory.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("rst_valid", if_to_id_valid, 1'b0);
        check("rst_bus", if_to_id_bus, '0);
        step(1, 0, 0, 1, 1);
        check("first_req_valid", req_valid, 1'b1);
        check("first_req_addr", req_addr, 32'h8000_0000);
        step(1, 0, 0, 1, 1);
        check("second_req_addr", req_addr, 32'h8000_0004);
        step(1, 0, 0, 1, 1);
        check("first_out_valid", if_to_id_valid, 1'b1);
        check("first_out_bus", if_to_id_bus, {1'b0, 32'h0000_0013, 32'h8000_0000});
        step(1, 0, 0, 1, 1);
        check("ebreak_bus", if_to_id_bus, {1'b1, 32'h0010_0073, 32'h8000_0004});
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 1, 1);
            check("thru_valid", if_to_id_valid, 1'b1);
            check("thru_pc", if_to_id_bus[31:0], 32'h8000_0008 + 32'(4 * i));
        end

        // ID stalled: queue fills to DEPTH, then drains in order.
        step(0, 0, 0, 1, 0);
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, 1, 0);
            if (req_valid && req_ready) acc++;
        end
        check("stall_accepts", 32'(acc), 32'd4);
        check("stall_req_valid", req_valid, 1'b0);
        k = 0; seen = 0;
        for (int i = 0; i < 12 && k < 5; i++) begin
            step(1, 0, 0, 1, 1);
            if (!seen && req_valid) begin
                seen = 1;
                check("resume_addr", req_addr, 32'h8000_0010);
            end
            if (if_to_id_valid) begin
                check("drain_pc", if_to_id_bus[31:0], 32'h8000_0000 + 32'(4 * k));
                k++;
            end
        end
        check("drain_count", 32'(k), 32'd5);

        // Redirect with two requests in flight at latency 3.
        step(0, 0, 0, 1, 1);
        lat = 3;
        step(1, 0, 0, 1, 1);
        step(1, 0, 0, 1, 1);
        step(1, 1, 32'h8000_0100, 1, 1);
        check("redir_req_valid", req_valid, 1'b0);
        step(1, 0, 0, 1, 1);
        check("redir_req_addr", req_addr, 32'h8000_0100);
        seen = 0;
        for (int i = 0; i < 15 && !seen; i++) begin
            if (if_to_id_valid) begin
                seen = 1;
                check("redir_first_pc", if_to_id_bus[31:0], 32'h8000_0100);
            end else begin
                step(1, 0, 0, 1, 1);
            end
        end
        check("redir_out_seen", seen, 1'b1);

        // Redirect colliding with a response and a pending dequeue.
        step(0, 0, 0, 1, 1);
        lat = 1;
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 1);
        step(1, 1, 32'h8000_0200, 1, 1);
        check("coll_valid", if_to_id_valid, 1'b0);
        check("coll_req_valid", req_valid, 1'b0);
        step(1, 0, 0, 1, 1);
        check("coll_req_valid_next", req_valid, 1'b1);
        check("coll_req_addr", req_addr, 32'h8000_0200);

        // Reset in the middle of traffic.
        lat = 3;
        for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1);
        check("mid_rst_valid", if_to_id_valid, 1'b0);
        check("mid_rst_bus", if_to_id_bus, '0);
        check("mid_rst_fetch_pc", fetch_pc, RST_PC);
        check("mid_rst_req_valid", req_valid, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            lat = $urandom_range(1, 5);
            step($urandom_range(0, 199) != 0, $urandom_range(0, 19) == 0,
                 $urandom & 32'hFFFF_FFFC, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7);
        end

        @(posedge clk);
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ifu_prefetch_queue.md
Name: ifu_prefetch_queue

Overview:
Instruction-fetch front end that replaces the single-register IF stage with a decoupled prefetcher. It issues PC requests to a variable-latency instruction memory port and buffers up to DEPTH in-order fetches. It presents them to ID over the valid/allowin handshake. Branch redirects from ID flush the buffer and discard in-flight responses by counting them.

Parameters:
ADDR_W, 32, PC and request address width
RESET_PC, 32'h80000000, first fetch address after reset
DEPTH, 4, queue entries and maximum outstanding requests (power of 2, >=2)
MEM_DW, 64, response data width; one aligned 64-bit beat holds two instructions

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
redirect_valid  in  1  branch/jump taken in ID this cycle
redirect_pc  in  ADDR_W  redirect target
req_valid  out  1  fetch request valid
req_ready  in  1  memory accepts request
req_addr  out  ADDR_W  fetch PC, unmodified
resp_valid  in  1  in-order response beat
resp_data  in  MEM_DW  aligned doubleword containing the instruction
id_allowin  in  1  ID can accept
if_to_id_valid  out  1  head entry valid to ID
if_to_id_bus  out  33+ADDR_W  {ebreak, inst[31:0], pc}
fetch_pc  out  ADDR_W  next PC to be requested (debug/difftest)

Behaviour:
- Reset: rst==0 sampled at posedge. All entries freed, drop_cnt=0, fetch_pc=RESET_PC, req_valid=0, if_to_id_valid=0, bus=0. Reset mid-operation abandons in-flight responses. The memory side is reset together.
- Entry fields: pc, inst, ebreak, filled. Circular queue with head/tail pointers and occupancy count (0..DEPTH).
- Allocation: req_valid = rst && !redirect_valid && (count + drop_cnt < DEPTH). On req_valid&&req_ready, the tail entry is allocated with pc=fetch_pc and filled=0, tail++, and fetch_pc += 4.
- Fill: resp_valid with drop_cnt==0 fills the oldest unfilled entry. inst = pc[2] ? data[63:32] : data[31:0]. ebreak = (inst == 32'h00100073). Responses arrive strictly in request order. A response with no outstanding request is a protocol error (assertion).
- Output: if_to_id_valid = head.filled && !redirect_valid. The bus is driven from the head entry. Dequeue happens on if_to_id_valid && id_allowin, then head++.
- Latency: a request accepted at cycle t with response at t+L gives if_to_id_valid at t+L+1, provided it is the head.
- Throughput: 1 instruction/cycle sustained when L <= DEPTH-1 and ID never stalls.
- Redirect (priority over everything):
  - drop_cnt += number of allocated-but-unfilled entries.
  - All entries are freed (count=0, head=tail).
  - fetch_pc = redirect_pc.
  - No request is issued and no dequeue occurs that cycle.
  - A resp_valid in the redirect cycle belongs to the old stream: it is discarded and counted in the drop_cnt update.
- Drop: while drop_cnt>0, each resp_valid is discarded and drop_cnt decrements. Slots are credited only when the decrement occurs.
- Full: count+drop_cnt==DEPTH forces req_valid=0. A dequeue and an allocation in the same cycle keep count unchanged.
- Empty: if_to_id_valid=0. Filled entries stay ordered; a non-head filled entry is never presented.
- Simultaneous fill and dequeue of the same head: fill first, presentation the next cycle. No combinational bypass.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Count is distinguished separately.
- req_addr equals fetch_pc. req_valid may drop when credits are exhausted, even with no handshake.

Decomposition:
- Shared package holds:
  - IF_TO_ID_WIDTH (33+ADDR_W)
  - EBREAK_INST constant
  - bus field offsets (PC lsb 0, inst at ADDR_W, ebreak at MSB)
- Sub-module ifu_fetch_queue holds entry storage, pointers, count and fill pointer. Its ports are alloc/fill/deq/flush.
- The top holds fetch_pc, drop_cnt, request gating and instruction select.

Test Plan:
- Reset release, req_ready=1, L=1, id_allowin=1 -> requests 80000000, 80000004, 80000008...; first if_to_id_valid 2 cycles after the first request, then one per cycle. Inst for pc 80000004 is taken from data[63:32].
- id_allowin=0, L=1 -> exactly 4 requests accepted, then req_valid=0. On id_allowin=1, entries drain in order 80000000..8000000C and requests resume at 80000010.
- L=3, redirect to 80000100 with 2 requests in flight -> drop_cnt=2. The next 2 responses are discarded. The first output pc is 80000100 and no stale pc reaches ID.
- Redirect in the same cycle as resp_valid and a pending dequeue -> response dropped, if_to_id_valid=0 that cycle, no request issued. The next cycle's req_addr is the redirect target.
- Response data 0x00100073_00000013 at pc 80000004 -> bus ebreak=1, inst=00100073. At pc 80000000 -> ebreak=0, inst=00000013.
- rst=0 asserted with 3 entries and 2 outstanding -> next cycle count=0, fetch_pc=80000000, outputs 0. Restart fetches from RESET_PC.
